// File: rtl/seq_pkg.sv
// Shared definitions for the sequence counter slice: frame geometry,
// state encoding and the segment-to-count helper.
package seq_pkg;

  localparam int CNT_MAX = 198;  // frame length, count runs 0..CNT_MAX-1
  localparam int SEG_LEN = 13;   // steps per segment
  localparam int CNT_W   = 8;    // width of the shared count bus
  localparam int SEG_NUM = 16;   // segments per frame (last one is short)
  localparam int SEG_W   = 4;    // width of a segment index

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

  // First count of segment s, i.e. s*13, built from shifts and adds so no
  // multiplier is inferred.
  function automatic logic [CNT_W-1:0] seg_base(input logic [SEG_W-1:0] s);
    logic [CNT_W-1:0] w;
    w = CNT_W'(s);
    return (w << 3) + (w << 2) + w;
  endfunction

endpackage

// File: rtl/seg_tracker.sv
// Segment tracker: follows count incrementally with a position-in-segment
// sub-counter so the segment index never needs a divider.
// Ports:
//   sysclk, reset       clock, synchronous active-high reset
//   clr                 return to segment 0, position 0 (frame start / wrap)
//   inc                 one accepted step that does not end the frame
//   load, load_seg      jump to the start of segment load_seg
//   seg                 current segment index
//   seg_start           one-cycle strobe: count has just entered a boundary
module seg_tracker
  import seq_pkg::*;
(
  input  logic             sysclk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             load,
  input  logic [SEG_W-1:0] load_seg,
  output logic [SEG_W-1:0] seg,
  output logic             seg_start
);

  logic [SEG_W-1:0] seg_pos;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      seg_pos   <= '0;
      seg       <= '0;
      seg_start <= 1'b0;
    end else begin
      seg_start <= 1'b0;
      if (load) begin
        seg_pos   <= '0;
        seg       <= load_seg;
        seg_start <= 1'b1;
      end else if (clr) begin
        seg_pos   <= '0;
        seg       <= '0;
        seg_start <= 1'b1;
      end else if (inc) begin
        // Last step of a segment rolls into the next segment.
        if (seg_pos == SEG_W'(SEG_LEN - 1)) begin
          seg_pos   <= '0;
          seg       <= seg + 1'b1;
          seg_start <= 1'b1;
        end else begin
          seg_pos <= seg_pos + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seq_counter.sv
// Sequence counter driving the shared count bus. Advances on pulse strobes
// through one frame, wraps or stops at the frame end, and accepts seeks to
// the start of any segment over a valid/ready port.
// Ports:
//   sysclk, reset             clock, synchronous active-high reset
//   pulse                     advance strobe (acts only while running)
//   start, stop               run control
//   one_shot                  1: stop at frame end instead of wrapping
//   seek_valid, seek_seg      seek request and target segment
//   seek_ready                seek can be accepted this cycle
//   count, seg                current step and its segment
//   seg_start, wrap           one-cycle boundary / frame-end strobes
//   running                   FSM is in RUN
module seq_counter
  import seq_pkg::*;
(
  input  logic             sysclk,
  input  logic             reset,
  input  logic             pulse,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic             seek_valid,
  input  logic [SEG_W-1:0] seek_seg,
  output logic             seek_ready,
  output logic [CNT_W-1:0] count,
  output logic [SEG_W-1:0] seg,
  output logic             seg_start,
  output logic             wrap,
  output logic             running
);

  seq_state_t state;

  logic seek_acc;
  logic run_pulse;
  logic at_end;
  logic trk_clr;
  logic trk_inc;

  // An accepted seek outranks every control input; stop outranks a pulse.
  assign seek_acc  = seek_valid && seek_ready;
  assign run_pulse = !seek_acc && (state == RUN) && !stop && pulse;
  assign at_end    = (count == CNT_W'(CNT_MAX - 1));
  assign trk_clr   = !seek_acc && (((state == IDLE) && start) || (run_pulse && at_end));
  assign trk_inc   = run_pulse && !at_end;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      wrap       <= 1'b0;
      running    <= 1'b0;
      seek_ready <= 1'b1;
    end else begin
      wrap       <= 1'b0;
      // Ready drops only for the load cycle; it cannot be accepted while low.
      seek_ready <= !seek_acc;
      if (seek_acc) begin
        count <= seg_base(seek_seg);
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
              count   <= '0;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (pulse) begin
              if (at_end) begin
                count <= '0;
                wrap  <= 1'b1;
                if (one_shot) begin
                  state   <= IDLE;
                  running <= 1'b0;
                end
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          PAUSE: begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  seg_tracker u_seg_tracker (
    .sysclk    (sysclk),
    .reset     (reset),
    .clr       (trk_clr),
    .inc       (trk_inc),
    .load      (seek_acc),
    .load_seg  (seek_seg),
    .seg       (seg),
    .seg_start (seg_start)
  );

endmodule
